// File: rtl/serial_sub_ctrl_if.sv
// Operand/result bundle for the bit-serial subtractor.
// Master drives the request side; slave (the controller) drives status and results.
interface serial_sub_ctrl_if #(
   parameter int W = 8
);
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borr;
   logic         ovf;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, borr, ovf
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, borr, ovf
   );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full-subtractor cell time-shared LSB-first across a W-bit word.
// Computes diff = a - b - bin with final borrow and signed-overflow flag.
module serial_sub_ctrl #(
   parameter int W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   serial_sub_ctrl_if.slave  bus
);

   // Handshake: start is sampled only in IDLE or DONE; the accepting edge also samples
   // a/b/bin. busy is high for the W RUN cycles, then done pulses for one cycle with
   // diff/borr/ovf valid; results hold until the next completion.

   localparam int            CW   = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  a_sh_q, a_sh_d;
   logic [W-1:0]  b_sh_q, b_sh_d;
   logic [W-1:0]  res_q, res_d;
   logic          br_q, br_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  diff_q, diff_d;
   logic          borr_q, borr_d;
   logic          ovf_q, ovf_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic ai, bi, d_bit, br_next;

   always_comb begin
      ai      = a_sh_q[0];
      bi      = b_sh_q[0];
      d_bit   = ai ^ bi ^ br_q;
      br_next = (~ai & bi) | (~ai & br_q) | (bi & br_q);
   end

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      borr_d  = borr_q;
      ovf_d   = ovf_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d = RUN;
               a_sh_d  = bus.a;
               b_sh_d  = bus.b;
               br_d    = bus.bin;
               res_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end else begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         RUN: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            res_d  = {d_bit, res_q[W-1:1]};
            br_d   = br_next;
            if (cnt_q == LAST) begin
               // br_q here is the borrow into the MSB; XOR with borrow out gives overflow
               state_d = DONE;
               diff_d  = {d_bit, res_q[W-1:1]};
               borr_d  = br_next;
               ovf_d   = br_q ^ br_next;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         borr_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         borr_q  <= borr_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.diff = diff_q;
   assign bus.borr = borr_q;
   assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: directed vectors, multi-cycle corner sequences
// and random operands checked against an arithmetic reference model.
module tb_serial_sub_ctrl;

   localparam int W = 8;

   logic clk;
   logic rst_n;

   serial_sub_ctrl_if #(.W(W)) bus ();

   serial_sub_ctrl #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int both_hits = 0;

   logic [W+1:0] exp_q[$];

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] exp_diff;
      logic         exp_borr;
      logic         exp_ovf;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic, unsigned for borrow, signed for overflow.
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic bin);
      int ua, ub, sa, sb, ud, sd;
      logic borr, ovf;
      logic [W-1:0] diff;
      ua   = int'(a);
      ub   = int'(b);
      sa   = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
      sb   = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
      ud   = ua - ub - int'(bin);
      sd   = sa - sb - int'(bin);
      borr = (ud < 0);
      ovf  = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
      diff = W'(ud & ((1 << W) - 1));
      return {borr, ovf, diff};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      if (bus.busy && bus.done) both_hits++;
   endtask

   // Steps until done, at most W+4 cycles; lat counts edges taken.
   task automatic wait_done(output int lat);
      lat = 0;
      while (!bus.done && lat < W + 4) begin
         step();
         lat++;
      end
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input string tag, output logic [W+1:0] got);
      int lat;
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.bin   = bin;
      step();
      bus.start = 1'b0;
      bus.a     = $urandom();
      bus.b     = $urandom();
      bus.bin   = $urandom_range(0, 1);
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      wait_done(lat);
      check({tag, "_latency"}, 32'(lat), 32'(W));
      check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
      got = {bus.borr, bus.ovf, bus.diff};
      step();
      check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      logic [W+1:0] got, exp;
      int lat;

      vecs[0] = '{a: 8'h05, b: 8'h03, bin: 1'b0, exp_diff: 8'h02, exp_borr: 1'b0, exp_ovf: 1'b0};
      vecs[1] = '{a: 8'h03, b: 8'h05, bin: 1'b0, exp_diff: 8'hFE, exp_borr: 1'b1, exp_ovf: 1'b0};
      vecs[2] = '{a: 8'h80, b: 8'h01, bin: 1'b0, exp_diff: 8'h7F, exp_borr: 1'b0, exp_ovf: 1'b1};
      vecs[3] = '{a: 8'h7F, b: 8'hFF, bin: 1'b0, exp_diff: 8'h80, exp_borr: 1'b1, exp_ovf: 1'b1};
      vecs[4] = '{a: 8'h00, b: 8'h00, bin: 1'b1, exp_diff: 8'hFF, exp_borr: 1'b1, exp_ovf: 1'b0};
      vecs[5] = '{a: 8'hFF, b: 8'hFF, bin: 1'b1, exp_diff: 8'hFF, exp_borr: 1'b1, exp_ovf: 1'b0};

      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.bin   = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      check("reset_out", 32'({bus.borr, bus.ovf, bus.diff}), 32'd0);

      // Directed vectors
      for (int i = 0; i < 6; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].bin, $sformatf("vec%0d", i), got);
         check($sformatf("vec%0d_diff", i), 32'(got[W-1:0]), 32'(vecs[i].exp_diff));
         check($sformatf("vec%0d_borr", i), 32'(got[W+1]), 32'(vecs[i].exp_borr));
         check($sformatf("vec%0d_ovf", i), 32'(got[W]), 32'(vecs[i].exp_ovf));
      end

      // Start during RUN is ignored; back-to-back accept in DONE
      bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h01; bus.bin = 1'b0;
      step();
      bus.start = 1'b0;
      repeat (2) step();
      bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55;
      step();
      bus.start = 1'b0;
      wait_done(lat);
      check("ignore_done_seen", 32'(bus.done), 32'd1);
      check("ignore_diff", 32'(bus.diff), 32'h0F);
      bus.start = 1'b1; bus.a = 8'h20; bus.b = 8'h10; bus.bin = 1'b0;
      step();
      bus.start = 1'b0;
      check("b2b_busy", 32'(bus.busy), 32'd1);
      check("b2b_hold_diff", 32'(bus.diff), 32'h0F);
      wait_done(lat);
      check("b2b_spacing", 32'(lat + 1), 32'(W + 1));
      check("b2b_diff", 32'(bus.diff), 32'h10);
      step();

      // Reset mid-RUN aborts with no done pulse
      bus.start = 1'b1; bus.a = 8'h55; bus.b = 8'h11; bus.bin = 1'b0;
      step();
      bus.start = 1'b0;
      repeat (3) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_out", 32'({bus.borr, bus.ovf, bus.diff}), 32'd0);
      lat = 0;
      for (int i = 0; i < W + 3; i++) begin
         step();
         if (bus.done || bus.busy) lat++;
      end
      check("abort_no_done", 32'(lat), 32'd0);
      do_op(8'h09, 8'h04, 1'b0, "post_abort", got);
      check("post_abort_diff", 32'(got[W-1:0]), 32'h05);

      // Random operands via scoreboard
      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] ra, rb;
         logic rbin;
         ra   = W'($urandom());
         rb   = W'($urandom());
         rbin = 1'($urandom_range(0, 1));
         exp_q.push_back(model(ra, rb, rbin));
         do_op(ra, rb, rbin, "rnd", got);
         exp = exp_q.pop_front();
         if (got !== exp)
            $display("  operands a=0x%0h b=0x%0h bin=%0d", ra, rb, rbin);
         check("rnd_result", 32'(got), 32'(exp));
      end

      check("busy_done_excl", 32'(both_hits), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1, "timeout");
   end

endmodule
